// File: rtl/hs_arb_pkg.sv
// Shared types and index helpers for the handshake arbiters.
// The helpers keep index widths and wrap-around legal when the requester count is not a power of two.
package hs_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Modular add of two in-range indices using an explicit compare instead of overflow.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_handshake_arbiter_if.sv
// Bundle of upstream (NUM_REQ valid/ready lanes) and downstream handshake signals.
// The master modport is the traffic side; the slave modport is the arbiter.
interface rr_handshake_arbiter_if
  import hs_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = clog2_safe(NUM_REQ);

  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       last_up_in;
  logic [NUM_REQ-1:0]       valid_up_in;
  logic [NUM_REQ-1:0]       ready_up_out;
  logic [WIDTH-1:0]         data_out;
  logic                     last_down_out;
  logic [ID_W-1:0]          grant_id_out;
  logic                     valid_down_out;
  logic                     ready_down_in;

  modport master (
    output data_in, last_up_in, valid_up_in, ready_down_in,
    input  ready_up_out, data_out, last_down_out, grant_id_out, valid_down_out
  );

  modport slave (
    input  data_in, last_up_in, valid_up_in, ready_down_in,
    output ready_up_out, data_out, last_down_out, grant_id_out, valid_down_out
  );

endinterface

// File: rtl/rr_priority_sel.sv
// Round-robin request picker: rotate by ptr, take the lowest set bit, rotate the index back.
// Purely combinational; ptr must be below NUM_REQ.
module rr_priority_sel
  import hs_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    sel
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    first;

  // rot[0] is the request at ptr, so the fixed-priority stage favours ptr, ptr+1, ...
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[wrap_add(i, int'(ptr), NUM_REQ)];
    end
  end

  always_comb begin
    found = |rot;
    first = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = ID_W'(i);
    end
  end

  always_comb begin
    sel = ID_W'(wrap_add(int'(first), int'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// N:1 round-robin valid/ready arbiter with packet locking and one registered output stage.
// Only slot_free couples ready_down_in to ready_up_out combinationally.
module rr_handshake_arbiter
  import hs_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_handshake_arbiter_if.slave bus
);

  localparam int ID_W = clog2_safe(NUM_REQ);

  arb_state_e         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    rr_sel;
  logic               rr_found;
  logic [ID_W-1:0]    sel;
  logic               slot_free;
  logic [NUM_REQ-1:0] ready_up;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_last;
  logic               up_fire;
  logic               down_fire;

  logic [WIDTH-1:0]   data_q;
  logic               last_q;
  logic [ID_W-1:0]    grant_q;
  logic               valid_q;

  rr_priority_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req   (bus.valid_up_in),
    .ptr   (ptr),
    .found (rr_found),
    .sel   (rr_sel)
  );

  // A locked burst keeps the owner selected even while its valid is low.
  always_comb begin
    sel       = (state == ARB_BURST) ? owner : rr_sel;
    slot_free = !valid_q || bus.ready_down_in;
    ready_up  = '0;
    if (rst_n && (state == ARB_BURST || rr_found)) begin
      ready_up[sel] = slot_free;
    end
    sel_data  = bus.data_in[sel*WIDTH +: WIDTH];
    sel_last  = bus.last_up_in[sel];
    up_fire   = bus.valid_up_in[sel] && ready_up[sel];
    down_fire = valid_q && bus.ready_down_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      // A new beat overwrites a departing one in the same cycle, so there is no bubble.
      if (up_fire) begin
        data_q  <= sel_data;
        last_q  <= sel_last;
        grant_q <= sel;
        valid_q <= 1'b1;
      end else if (down_fire) begin
        valid_q <= 1'b0;
      end

      if (up_fire && sel_last) begin
        ptr <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      end

      case (state)
        ARB_IDLE: begin
          if (up_fire && !sel_last) begin
            state <= ARB_BURST;
            owner <= sel;
          end
        end
        ARB_BURST: begin
          if (up_fire && sel_last) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ready_up_out   = ready_up;
  assign bus.data_out       = data_q;
  assign bus.last_down_out  = last_q;
  assign bus.grant_id_out   = grant_q;
  assign bus.valid_down_out = valid_q;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter (NUM_REQ=4, WIDTH=32) plus a randomised
// traffic phase with an in-order per-requester scoreboard.
module tb_rr_handshake_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int N_RAND  = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_handshake_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  rr_handshake_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] d, input logic l);
    bus.valid_up_in[i]             = v;
    bus.data_in[i*WIDTH +: WIDTH]  = d;
    bus.last_up_in[i]              = l;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [1:0] g,
                             input logic l);
    check({tag, "_valid"}, bus.valid_down_out, 1'b1);
    check({tag, "_data"},  bus.data_out, d);
    check({tag, "_grant"}, bus.grant_id_out, g);
    check({tag, "_last"},  bus.last_down_out, l);
  endtask

  // Random-phase scoreboard state
  logic [15:0] seq_tx [NUM_REQ];
  logic [15:0] seq_rx [NUM_REQ];
  int          sent   [NUM_REQ];
  int          recv   [NUM_REQ];
  logic        open_tx[NUM_REQ];
  logic        pkt_open;
  logic [1:0]  pkt_owner;
  logic [3:0]  fire_v;
  logic        prev_stall;
  logic [31:0] snap_d;
  logic [1:0]  snap_g;
  logic        snap_l;

  initial begin
    logic [31:0] d;
    logic [1:0]  g;
    logic        l;
    logic        drain;

    rst_n              = 1'b0;
    bus.data_in        = '0;
    bus.last_up_in     = '0;
    bus.valid_up_in    = '0;
    bus.ready_down_in  = 1'b1;
    #1;
    check("rst0_valid", bus.valid_down_out, 1'b0);
    check("rst0_data",  bus.data_out, 32'h0);
    check("rst0_ready", bus.ready_up_out, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;

    // Fairness: four single-beat requesters rotate 0,1,2,3,0 back to back
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 32'hA0 + i, 1'b1);
    settle();
    check("fair_ready", bus.ready_up_out, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_beat("fair", 32'hA0 + (k % 4), 2'(k % 4), 1'b1);
    end
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, 32'h0, 1'b0);
    tick();
    check("fair_drain_valid", bus.valid_down_out, 1'b0);
    check("fair_drain_hold",  bus.data_out, 32'hA0);

    // Burst lock: ptr=1, req2 bursts while req0/req3 wait; then 3, then 0
    drive(2, 1'b1, 32'h20, 1'b0);
    drive(0, 1'b1, 32'h50, 1'b1);
    drive(3, 1'b1, 32'h53, 1'b1);
    settle();
    check("burst_ready0", bus.ready_up_out, 4'b0100);
    tick();
    expect_beat("burst_b0", 32'h20, 2'd2, 1'b0);
    drive(2, 1'b1, 32'h21, 1'b0);
    settle();
    check("burst_ready1", bus.ready_up_out, 4'b0100);
    tick();
    expect_beat("burst_b1", 32'h21, 2'd2, 1'b0);
    drive(2, 1'b1, 32'h22, 1'b1);
    tick();
    expect_beat("burst_b2", 32'h22, 2'd2, 1'b1);
    drive(2, 1'b0, 32'h0, 1'b0);
    settle();
    check("burst_next3", bus.ready_up_out, 4'b1000);
    tick();
    expect_beat("burst_r3", 32'h53, 2'd3, 1'b1);
    drive(3, 1'b0, 32'h0, 1'b0);
    settle();
    check("burst_next0", bus.ready_up_out, 4'b0001);
    tick();
    expect_beat("burst_r0", 32'h50, 2'd0, 1'b1);
    drive(0, 1'b0, 32'h0, 1'b0);
    tick();
    check("burst_idle", bus.valid_down_out, 1'b0);

    // Backpressure: ptr=1; five stalled cycles must hold the output and withhold ready
    drive(1, 1'b1, 32'h61, 1'b1);
    drive(2, 1'b1, 32'h62, 1'b1);
    tick();
    expect_beat("bp_first", 32'h61, 2'd1, 1'b1);
    drive(1, 1'b0, 32'h0, 1'b0);
    bus.ready_down_in = 1'b0;
    settle();
    check("bp_noready", bus.ready_up_out, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_beat("bp_hold", 32'h61, 2'd1, 1'b1);
      check("bp_hold_ready", bus.ready_up_out, 4'b0000);
    end
    bus.ready_down_in = 1'b1;
    settle();
    check("bp_release_ready", bus.ready_up_out, 4'b0100);
    tick();
    expect_beat("bp_after", 32'h62, 2'd2, 1'b1);
    drive(2, 1'b0, 32'h0, 1'b0);
    tick();
    check("bp_idle", bus.valid_down_out, 1'b0);

    // Owner gap: ptr=3; req1 bursts and pauses, req2 must not be granted meanwhile
    drive(1, 1'b1, 32'h71, 1'b0);
    drive(2, 1'b1, 32'h72, 1'b1);
    settle();
    check("gap_ready0", bus.ready_up_out, 4'b0010);
    tick();
    expect_beat("gap_b0", 32'h71, 2'd1, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("gap_locked", bus.ready_up_out, 4'b0010);
      tick();
    end
    check("gap_bubble", bus.valid_down_out, 1'b0);
    drive(1, 1'b1, 32'h7F, 1'b1);
    settle();
    check("gap_resume", bus.ready_up_out, 4'b0010);
    tick();
    expect_beat("gap_b1", 32'h7F, 2'd1, 1'b1);
    drive(1, 1'b0, 32'h0, 1'b0);
    settle();
    check("gap_release", bus.ready_up_out, 4'b0100);
    tick();
    expect_beat("gap_r2", 32'h72, 2'd2, 1'b1);
    drive(2, 1'b0, 32'h0, 1'b0);
    tick();

    // Reset mid-burst: ptr=3, req3 locks, then reset discards lock, pointer and beat
    drive(3, 1'b1, 32'h90, 1'b0);
    settle();
    check("mrst_pre_ready", bus.ready_up_out, 4'b1000);
    tick();
    expect_beat("mrst_pre", 32'h90, 2'd3, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 32'hB0 + i, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.valid_down_out, 1'b0);
    check("mrst_data",  bus.data_out, 32'h0);
    check("mrst_grant", bus.grant_id_out, 2'd0);
    check("mrst_last",  bus.last_down_out, 1'b0);
    check("mrst_ready", bus.ready_up_out, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check("mrst_first_ready", bus.ready_up_out, 4'b0001);
    tick();
    expect_beat("mrst_first", 32'hB0, 2'd0, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, 32'h0, 1'b0);
    tick();

    // Random traffic with in-order scoreboard, no-interleave and stall-stability checks
    for (int i = 0; i < NUM_REQ; i++) begin
      seq_tx[i]  = '0;
      seq_rx[i]  = '0;
      sent[i]    = 0;
      recv[i]    = 0;
      open_tx[i] = 1'b0;
    end
    pkt_open   = 1'b0;
    pkt_owner  = '0;
    prev_stall = 1'b0;
    snap_d     = '0;
    snap_g     = '0;
    snap_l     = 1'b0;

    for (int cyc = 0; cyc < N_RAND + 100; cyc++) begin
      drain = (cyc >= N_RAND);
      @(negedge clk);
      check("rnd_onehot0", 32'($onehot0(bus.ready_up_out)), 32'd1);
      if (prev_stall) begin
        check("rnd_stall_valid", bus.valid_down_out, 1'b1);
        check("rnd_stall_data",  bus.data_out, snap_d);
        check("rnd_stall_grant", bus.grant_id_out, snap_g);
        check("rnd_stall_last",  bus.last_down_out, snap_l);
      end
      if (bus.valid_down_out && bus.ready_down_in) begin
        d = bus.data_out;
        g = bus.grant_id_out;
        check("rnd_src",  d[31:24], 32'(g));
        check("rnd_seq",  d[15:0], seq_rx[g]);
        check("rnd_last", bus.last_down_out, d[16]);
        if (pkt_open) check("rnd_interleave", g, pkt_owner);
        seq_rx[g] = seq_rx[g] + 16'd1;
        recv[g]++;
        pkt_open  = !bus.last_down_out;
        pkt_owner = g;
      end
      prev_stall = bus.valid_down_out && !bus.ready_down_in;
      snap_d     = bus.data_out;
      snap_g     = bus.grant_id_out;
      snap_l     = bus.last_down_out;
      fire_v     = bus.valid_up_in & bus.ready_up_out;

      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire_v[i]) begin
          sent[i]++;
          seq_tx[i]  = seq_tx[i] + 16'd1;
          open_tx[i] = !bus.last_up_in[i];
          drive(i, 1'b0, 32'h0, 1'b0);
        end
        if (!bus.valid_up_in[i]) begin
          if (drain ? open_tx[i] : ($urandom_range(0, 2) != 0)) begin
            l = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
            drive(i, 1'b1, {8'(i), 7'd0, l, seq_tx[i]}, l);
          end
        end
      end
      bus.ready_down_in = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      check("rnd_count", 32'(recv[i]), 32'(sent[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
